// File: rtl/paint_cursor_blink.sv
// Cursor blink sequencer: saves the pixel under the cursor, then alternates it
// between WHITE and the saved colour, restoring it on move or disable.
module paint_cursor_blink #(
   parameter int                  X_W     = 5,
   parameter int                  Y_W     = 5,
   parameter int                  COLOR_W = 3,
   parameter logic [COLOR_W-1:0]  WHITE   = 3'b111
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 blink_en,
   input  logic [X_W-1:0]       cursor_x,
   input  logic [Y_W-1:0]       cursor_y,
   input  logic                 timer_done,
   input  logic [COLOR_W-1:0]   mem_rdata,
   input  logic                 mem_ack,
   output logic                 timer_clr,
   output logic                 timer_start,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [X_W+Y_W-1:0]   mem_addr,
   output logic [COLOR_W-1:0]   mem_wdata,
   output logic                 cursor_on
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_W,
      CLR_W,
      CNT_W,
      WR_B,
      CLR_B,
      CNT_B
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_latch;
   logic                  w_moved;
   logic [X_W+Y_W-1:0]    r_addr;
   logic [COLOR_W-1:0]    r_bg;

   assign w_moved  = ({cursor_y, cursor_x} != r_addr);
   assign mem_addr = r_addr;

   // The address is only re-latched on entry to RD, so it stays frozen for
   // the whole read/white/restore sequence of one pixel.
   always_comb begin
      w_next  = r_state;
      w_latch = 1'b0;
      case (r_state)
         IDLE: begin
            if (blink_en) begin
               w_next  = RD;
               w_latch = 1'b1;
            end
         end
         RD: begin
            if (mem_ack) w_next = WR_W;
         end
         WR_W: begin
            if (mem_ack) w_next = CLR_W;
         end
         CLR_W: w_next = CNT_W;
         CNT_W: begin
            if (timer_done || w_moved || !blink_en) w_next = WR_B;
         end
         WR_B: begin
            if (mem_ack) begin
               if (!blink_en) begin
                  w_next = IDLE;
               end else if (w_moved) begin
                  w_next  = RD;
                  w_latch = 1'b1;
               end else begin
                  w_next = CLR_B;
               end
            end
         end
         CLR_B: w_next = CNT_B;
         CNT_B: begin
            if (!blink_en) begin
               w_next = IDLE;
            end else if (timer_done || w_moved) begin
               w_next  = RD;
               w_latch = 1'b1;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet
   // still line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_bg        <= '0;
         timer_clr   <= 1'b0;
         timer_start <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_wdata   <= '0;
         cursor_on   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_latch) r_addr <= {cursor_y, cursor_x};
         if (r_state == RD && mem_ack) r_bg <= mem_rdata;

         timer_clr   <= (w_next == CLR_W) || (w_next == CLR_B);
         timer_start <= (w_next == CNT_W) || (w_next == CNT_B);
         mem_req     <= (w_next == RD) || (w_next == WR_W) || (w_next == WR_B);
         mem_we      <= (w_next == WR_W) || (w_next == WR_B);
         cursor_on   <= (w_next == CLR_W) || (w_next == CNT_W);
         if (w_next == WR_W)
            mem_wdata <= WHITE;
         else if (w_next == WR_B)
            mem_wdata <= r_bg;
         else
            mem_wdata <= '0;
      end
   end

endmodule

// File: tb/tb_paint_cursor_blink.sv
// Directed cycle-by-cycle bench for paint_cursor_blink: each table row gives the
// inputs for one cycle and the outputs expected in that same cycle.
module tb_paint_cursor_blink;

   logic       clk = 1'b0;
   logic       rst;
   logic       blink_en;
   logic [4:0] cursor_x;
   logic [4:0] cursor_y;
   logic       timer_done;
   logic [2:0] mem_rdata;
   logic       mem_ack;
   logic       timer_clr;
   logic       timer_start;
   logic       mem_req;
   logic       mem_we;
   logic [9:0] mem_addr;
   logic [2:0] mem_wdata;
   logic       cursor_on;

   int checks = 0;
   int errors = 0;

   paint_cursor_blink #(
      .X_W(5), .Y_W(5), .COLOR_W(3), .WHITE(3'b111)
   ) dut (
      .clk(clk), .rst(rst), .blink_en(blink_en),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .timer_done(timer_done), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .timer_clr(timer_clr), .timer_start(timer_start),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cursor_on(cursor_on)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       en;
      logic [4:0] x;
      logic [4:0] y;
      logic       ack;
      logic [2:0] rdata;
      logic       done;
      logic       req;
      logic       we;
      logic [9:0] addr;
      logic [2:0] wdata;
      logic       clr;
      logic       start;
      logic       on;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input logic r, input logic e, input logic [4:0] x,
                         input logic [4:0] y, input logic a, input logic [2:0] rd,
                         input logic d, input logic req, input logic we,
                         input logic [9:0] addr, input logic [2:0] wd,
                         input logic clr, input logic st, input logic on);
      vec_t v;
      v.rst = r; v.en = e; v.x = x; v.y = y; v.ack = a; v.rdata = rd; v.done = d;
      v.req = req; v.we = we; v.addr = addr; v.wdata = wd;
      v.clr = clr; v.start = st; v.on = on;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      rst        = v.rst;
      blink_en   = v.en;
      cursor_x   = v.x;
      cursor_y   = v.y;
      mem_ack    = v.ack;
      mem_rdata  = v.rdata;
      timer_done = v.done;
   endtask

   task automatic checkOutput(input string name, input logic [17:0] act,
                              input logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got req/we/addr/wdata/clr/start/on=%b_%b_%h_%b_%b_%b_%b want %b_%b_%h_%b_%b_%b_%b",
                  name, act[17], act[16], act[15:6], act[5:3], act[2], act[1], act[0],
                  exp[17], exp[16], exp[15:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
   endtask

   function automatic logic [17:0] outBus();
      return {mem_req, mem_we, mem_addr, mem_wdata, timer_clr, timer_start, cursor_on};
   endfunction

   initial begin
      int waited;
      //     rst en x  y  ack rd    dn   req we addr    wd   clr st on
      // reset held three cycles with blink_en high
      addVec(1, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h000, 3'd0, 0, 0, 0);
      addVec(1, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h000, 3'd0, 0, 0, 0);
      addVec(1, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h000, 3'd0, 0, 0, 0);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h000, 3'd0, 0, 0, 0);
      // basic blink on pixel 3'b010
      addVec(0, 1, 3, 5, 1, 3'b010, 0, 1, 0, 10'h0A3, 3'd0, 0, 0, 0);
      addVec(0, 1, 3, 5, 1, 3'd0, 0,   1, 1, 10'h0A3, 3'b111, 0, 0, 0);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 1, 0, 1);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 0, 1, 1);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 0, 1, 1);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 0, 1, 1);
      addVec(0, 1, 3, 5, 0, 3'd0, 1,   0, 0, 10'h0A3, 3'd0, 0, 1, 1);
      addVec(0, 1, 3, 5, 1, 3'd0, 1,   1, 1, 10'h0A3, 3'b010, 0, 0, 0);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 1, 0, 0);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 0, 1, 0);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 0, 1, 0);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 0, 1, 0);
      addVec(0, 1, 3, 5, 0, 3'd0, 1,   0, 0, 10'h0A3, 3'd0, 0, 1, 0);
      // re-read picks up the repainted background 3'b100
      addVec(0, 1, 3, 5, 1, 3'b100, 0, 1, 0, 10'h0A3, 3'd0, 0, 0, 0);
      addVec(0, 1, 3, 5, 1, 3'd0, 0,   1, 1, 10'h0A3, 3'b111, 0, 0, 0);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 1, 0, 1);
      // cursor moves to (4,5) during the white phase
      addVec(0, 1, 4, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 0, 1, 1);
      addVec(0, 1, 4, 5, 1, 3'd0, 0,   1, 1, 10'h0A3, 3'b100, 0, 0, 0);
      addVec(0, 1, 4, 5, 1, 3'b001, 0, 1, 0, 10'h0A4, 3'd0, 0, 0, 0);
      // blink_en drops during WR_W with the ack delayed three cycles
      addVec(0, 0, 4, 5, 0, 3'd0, 0,   1, 1, 10'h0A4, 3'b111, 0, 0, 0);
      addVec(0, 0, 4, 5, 0, 3'd0, 0,   1, 1, 10'h0A4, 3'b111, 0, 0, 0);
      addVec(0, 0, 4, 5, 0, 3'd0, 0,   1, 1, 10'h0A4, 3'b111, 0, 0, 0);
      addVec(0, 0, 4, 5, 1, 3'd0, 0,   1, 1, 10'h0A4, 3'b111, 0, 0, 0);
      addVec(0, 0, 4, 5, 0, 3'd0, 0,   0, 0, 10'h0A4, 3'd0, 1, 0, 1);
      addVec(0, 0, 4, 5, 0, 3'd0, 0,   0, 0, 10'h0A4, 3'd0, 0, 1, 1);
      addVec(0, 0, 4, 5, 1, 3'd0, 0,   1, 1, 10'h0A4, 3'b001, 0, 0, 0);
      addVec(0, 0, 4, 5, 0, 3'd0, 0,   0, 0, 10'h0A4, 3'd0, 0, 0, 0);
      // restart, then reset while WR_B waits for its ack
      addVec(0, 1, 4, 5, 0, 3'd0, 0,   0, 0, 10'h0A4, 3'd0, 0, 0, 0);
      addVec(0, 1, 4, 5, 1, 3'b001, 0, 1, 0, 10'h0A4, 3'd0, 0, 0, 0);
      addVec(0, 1, 4, 5, 1, 3'd0, 0,   1, 1, 10'h0A4, 3'b111, 0, 0, 0);
      addVec(0, 1, 4, 5, 0, 3'd0, 0,   0, 0, 10'h0A4, 3'd0, 1, 0, 1);
      addVec(0, 1, 4, 5, 0, 3'd0, 1,   0, 0, 10'h0A4, 3'd0, 0, 1, 1);
      addVec(0, 1, 4, 5, 0, 3'd0, 1,   1, 1, 10'h0A4, 3'b001, 0, 0, 0);
      addVec(1, 1, 4, 5, 0, 3'd0, 1,   1, 1, 10'h0A4, 3'b001, 0, 0, 0);
      addVec(0, 0, 3, 5, 0, 3'd0, 0,   0, 0, 10'h000, 3'd0, 0, 0, 0);
      // disable beats timer_done in the dark phase
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h000, 3'd0, 0, 0, 0);
      addVec(0, 1, 3, 5, 1, 3'b010, 0, 1, 0, 10'h0A3, 3'd0, 0, 0, 0);
      addVec(0, 1, 3, 5, 1, 3'd0, 0,   1, 1, 10'h0A3, 3'b111, 0, 0, 0);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 1, 0, 1);
      addVec(0, 1, 3, 5, 0, 3'd0, 1,   0, 0, 10'h0A3, 3'd0, 0, 1, 1);
      addVec(0, 1, 3, 5, 1, 3'd0, 1,   1, 1, 10'h0A3, 3'b010, 0, 0, 0);
      addVec(0, 1, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 1, 0, 0);
      addVec(0, 0, 3, 5, 0, 3'd0, 1,   0, 0, 10'h0A3, 3'd0, 0, 1, 0);
      addVec(0, 0, 3, 5, 0, 3'd0, 0,   0, 0, 10'h0A3, 3'd0, 0, 0, 0);

      rst = 1'b1; blink_en = 1'b0; cursor_x = '0; cursor_y = '0;
      timer_done = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         checkOutput($sformatf("row%0d", i), outBus(),
                     {vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                      vecs[i].clr, vecs[i].start, vecs[i].on});
      end

      // Hand sequence: start at (1,2) and wait, bounded, for the read request
      @(negedge clk);
      cursor_x = 5'd1; cursor_y = 5'd2; blink_en = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!mem_req && waited < 10) begin
         waited++;
         @(negedge clk);
      end
      checks++;
      if (waited != 0) begin
         errors++;
         $display("[TB] FAIL start_latency: got %0d extra cycles want 0", waited);
      end
      checkOutput("hand_read", outBus(), {1'b1, 1'b0, 10'h041, 3'd0, 1'b0, 1'b0, 1'b0});
      mem_ack = 1'b1; mem_rdata = 3'b101;
      @(negedge clk);
      mem_ack = 1'b0;
      checkOutput("hand_white", outBus(), {1'b1, 1'b1, 10'h041, 3'b111, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      checkOutput("hand_hold", outBus(), {1'b1, 1'b1, 10'h041, 3'b111, 1'b0, 1'b0, 1'b0});
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; blink_en = 1'b0;
      checkOutput("hand_clr", outBus(), {1'b0, 1'b0, 10'h041, 3'd0, 1'b1, 1'b0, 1'b1});
      @(negedge clk);
      @(negedge clk);
      checkOutput("hand_restore", outBus(), {1'b1, 1'b1, 10'h041, 3'b101, 1'b0, 1'b0, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/paint_cursor_blink.md
# paint_cursor_blink

Cursor blink sequencer for the paint ASM. It saves the frame-buffer pixel under the cursor, then alternates that pixel between white and the saved colour. Each phase is timed by the white-count timer stage, which sits directly downstream and is driven through `timer_clr`, `timer_start` and `timer_done`. The block restores the saved pixel whenever the cursor moves or blinking is disabled, so painting never leaves a stray white pixel.

## Interface
Parameters:
- X_W, 5, cursor column width
- Y_W, 5, cursor row width
- COLOR_W, 3, pixel colour width
- WHITE, 3'b111, colour written during the white phase

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- blink_en  in  1  level; enables blinking
- cursor_x  in  X_W  cursor column
- cursor_y  in  Y_W  cursor row
- timer_done  in  1  level from timer stage; high once the programmed count has elapsed, held until the timer is cleared
- mem_rdata  in  COLOR_W  read data, valid in the cycle `mem_ack`=1 for a read
- mem_ack  in  1  one-cycle completion pulse for the current request
- timer_clr  out  1  one-cycle clear pulse to the timer stage
- timer_start  out  1  held high while a phase is being timed
- mem_req  out  1  frame-buffer request, held until `mem_ack`
- mem_we  out  1  1 = write, 0 = read; valid while `mem_req`=1
- mem_addr  out  X_W+Y_W  {row, column} of the latched cursor
- mem_wdata  out  COLOR_W  write data
- cursor_on  out  1  high during the white phase

## Operation
- Registers:
  - `addr_q`: latched {cursor_y, cursor_x}.
  - `bg_q`: saved colour.
  - `moved` = ({cursor_y, cursor_x} != `addr_q`), combinational.
- `mem_addr` always equals `addr_q`.
- Moore outputs; all outputs are 0 unless listed for the state.
- Each state, its outputs, and its transitions:
  - IDLE: if `blink_en`, latch `addr_q` and go to RD.
  - RD: `mem_req`=1, `mem_we`=0. On `mem_ack`, `bg_q` <= `mem_rdata`, go to WR_W.
  - WR_W: `mem_req`=1, `mem_we`=1, `mem_wdata`=WHITE. On `mem_ack`, go to CLR_W.
  - CLR_W: `timer_clr`=1, `cursor_on`=1. Next state is CNT_W.
  - CNT_W: `timer_start`=1, `cursor_on`=1. On `timer_done`, `moved`, or !`blink_en`, go to WR_B.
  - WR_B: `mem_req`=1, `mem_we`=1, `mem_wdata`=`bg_q`. On `mem_ack`, transitions are in priority order:
    - !`blink_en` -> IDLE.
    - `moved` -> RD, latching `addr_q`.
    - otherwise -> CLR_B.
  - CLR_B: `timer_clr`=1. Next state is CNT_B.
  - CNT_B: `timer_start`=1. Transitions in priority order:
    - !`blink_en` -> IDLE.
    - `timer_done` or `moved` -> RD, latching `addr_q`. The background is re-sampled every period, so strokes painted during the dark phase are preserved.
- Address latching:
  - `addr_q` is loaded only on the transitions into RD.
  - While a request is pending, the address is frozen even if the cursor moves.
- Request rules:
  - Once `mem_req` rises, `mem_we`, `mem_addr` and `mem_wdata` are held stable until the `mem_ack` cycle.
  - `mem_req` is never withdrawn without an ack, except on `rst`.
- Disable rule: `blink_en` dropping while in RD or WR_W does not abort. The sequence completes through WR_B, so the pixel is always restored.
- Ignored input: `timer_done` is ignored in every state other than CNT_W and CNT_B.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0.
  - `addr_q` and `bg_q` are 0.
- Reset mid-request: `rst` in any state returns to IDLE next edge and drops `mem_req`. A pixel left white by a reset is the clearing stage's responsibility.
- Start latency: `blink_en` rises in cycle 0 -> `mem_req` (read) is high from cycle 1.
- Request duration: each memory access lasts until `mem_ack`; the next state is entered on the following edge. With `mem_ack` in the first request cycle, each access takes 1 cycle.
- White-phase timing:
  - The cycle after the white write is acked carries `timer_clr`=1.
  - `timer_start` rises the cycle after `timer_clr`.
  - `timer_done` sampled high in CNT_W -> the WR_B request starts the next cycle.
- Simultaneous events in CNT_W: `moved` and `timer_done` in the same cycle give identical behaviour (go to WR_B).
- Simultaneous events in CNT_B: !`blink_en` has priority over `timer_done`/`moved`.
- `cursor_on` is high exactly in CLR_W and CNT_W.

## Test plan
- Reset behaviour: reset, then hold `rst` 3 cycles while `blink_en`=1 -> all outputs 0. `mem_req` rises 1 cycle after `rst` falls, with `mem_addr`=10'h0A3 for cursor (x=3, y=5).
- Basic blink:
  - Setup: pixel holds 3'b010, ack on the first request cycle, timer model asserts `timer_done` 4 cycles after `timer_start` rises.
  - Required sequence: read, write 3'b111, `timer_clr` pulse, `cursor_on` high for 5 cycles, write 3'b010, `timer_clr` pulse, dark phase, read again.
- Cursor move during the white phase: move (3,5)->(4,5) in CNT_W -> write 3'b010 to 10'h0A3, then read at 10'h0A4. No write of WHITE to 10'h0A3 occurs afterwards.
- Disable: drop `blink_en` during WR_W with ack delayed 3 cycles -> `mem_req`/`mem_we`/`mem_wdata` are stable for 4 cycles, the background is restored, and the block ends in IDLE with all outputs 0.
- Background repaint: change the pixel to 3'b100 during CNT_B -> the next read captures 3'b100, and the following WR_B writes 3'b100.
- Reset mid-write: assert `rst` during WR_B with no ack -> `mem_req`=0 on the next edge, IDLE, `timer_start`=0.
